// File: rtl/sys_xbar_pkg.sv
// sys_xbar_pkg: address map, shared types and the region decoder for the system crossbar.
// Region field values select a slave; anything not listed is an unmapped access.
package sys_xbar_pkg;

   localparam int MAX_SLV = 16;

   typedef logic [3:0] slv_idx_t;

   typedef struct packed {
      logic     hit;
      slv_idx_t idx;
   } dec_t;

   // Entries past the instantiated slave count never match because decode stops at num_s.
   localparam logic [7:0] REGION_ID [MAX_SLV] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, 8'hFF, 8'hFF, 8'hFF,
      8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
   };

   // Scans from the top down so that the lowest matching slave index is what remains.
   function automatic dec_t region_decode(input logic [7:0] region, input int num_s);
      dec_t r;
      r = '{hit: 1'b0, idx: 4'd0};
      for (int s = MAX_SLV - 1; s >= 0; s--) begin
         r = ((s < num_s) && (region == REGION_ID[s])) ? '{hit: 1'b1, idx: slv_idx_t'(s)} : r;
      end
      return r;
   endfunction

endpackage

// File: rtl/sys_xbar_rr_arb.sv
// sys_xbar_rr_arb: per-slave round-robin arbiter with a bounded ownership lock.
// The previous owner is always ptr-1, since the pointer advances past every grant.
module sys_xbar_rr_arb
   import sys_xbar_pkg::*;
#(
   parameter int NUM_M    = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_M-1:0] cand,
   input  logic             keep,
   output logic [NUM_M-1:0] gnt
);

   localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   logic [PW-1:0] ptr_r;
   logic [PW-1:0] ptr_nxt_s;
   logic [PW-1:0] owner_s;
   logic [PW-1:0] win_s;
   logic [HW-1:0] hold_r;
   logic [HW-1:0] hold_nxt_s;
   logic          others_s;
   logic          expired_s;
   logic          found_s;
   int            idx_s;

   // Owner lookup, lock expiry and the round-robin search.
   always_comb begin
      owner_s   = (ptr_r == {PW{1'b0}}) ? PW'(NUM_M - 1) : (ptr_r - PW'(1));
      others_s  = |(cand & ~(NUM_M'(1) << owner_s));
      expired_s = (hold_r == HW'(MAX_HOLD - 1)) && others_s;
      win_s     = owner_s;
      found_s   = 1'b0;
      idx_s     = 0;
      if (keep && !expired_s) begin
         win_s   = owner_s;
         found_s = 1'b1;
      end else begin
         for (int i = 0; i < NUM_M; i++) begin
            idx_s = (int'(ptr_r) + i) % NUM_M;
            if (!found_s && cand[idx_s]) begin
               win_s   = PW'(idx_s);
               found_s = 1'b1;
            end else begin
               win_s   = win_s;
            end
         end
      end
   end

   // Grant vector and next pointer/hold values; the counter saturates so expiry stays sticky.
   always_comb begin
      gnt        = (found_s && !rst) ? (NUM_M'(1) << win_s) : {NUM_M{1'b0}};
      ptr_nxt_s  = ptr_r;
      hold_nxt_s = {HW{1'b0}};
      if (found_s) begin
         ptr_nxt_s = (win_s == PW'(NUM_M - 1)) ? {PW{1'b0}} : (win_s + PW'(1));
         if (keep && !expired_s) begin
            hold_nxt_s = (hold_r == HW'(MAX_HOLD - 1)) ? hold_r : (hold_r + HW'(1));
         end else begin
            hold_nxt_s = {HW{1'b0}};
         end
      end else begin
         ptr_nxt_s  = ptr_r;
         hold_nxt_s = {HW{1'b0}};
      end
   end

   // Pointer and hold counter state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r  <= {PW{1'b0}};
         hold_r <= {HW{1'b0}};
      end else begin
         ptr_r  <= ptr_nxt_s;
         hold_r <= hold_nxt_s;
      end
   end

endmodule

// File: rtl/sys_xbar.sv
// sys_xbar: multi-master/multi-slave crossbar with per-slave arbitration and routed responses.
// Unmapped accesses are granted at once and answered with a one-cycle error pulse.
module sys_xbar
   import sys_xbar_pkg::*;
#(
   parameter int NUM_M    = 4,
   parameter int NUM_S    = 5,
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int DEC_MSB  = 31,
   parameter int DEC_LSB  = 28,
   parameter int MAX_HOLD = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [NUM_M-1:0]    i_m_req,
   output logic [NUM_M-1:0]    o_m_gnt,
   input  logic [NUM_M*AW-1:0] i_m_addr,
   input  logic [NUM_M-1:0]    i_m_write,
   input  logic [NUM_M-1:0]    i_m_read,
   input  logic [NUM_M*4-1:0]  i_m_size,
   input  logic [NUM_M*DW-1:0] i_m_din,
   output logic [NUM_M*DW-1:0] o_m_dout,
   output logic [NUM_M-1:0]    o_m_err,
   output logic [NUM_S*AW-1:0] o_s_addr,
   output logic [NUM_S-1:0]    o_s_write,
   output logic [NUM_S-1:0]    o_s_read,
   output logic [NUM_S*4-1:0]  o_s_size,
   output logic [NUM_S*DW-1:0] o_s_din,
   input  logic [NUM_S*DW-1:0] i_s_dout
);

   localparam int RW = DEC_MSB - DEC_LSB + 1;

   dec_t             dec_s   [NUM_M];
   logic [NUM_M-1:0] cand_s  [NUM_S];
   logic [NUM_M-1:0] sgnt_s  [NUM_S];
   logic [NUM_M-1:0] sgnt_r  [NUM_S];
   logic [NUM_S-1:0] keep_s;
   logic [NUM_M-1:0] unmap_s;
   logic [NUM_M-1:0] rd_s;
   slv_idx_t         rsp_sel_r [NUM_M];
   logic [NUM_M-1:0] rsp_vld_r;
   logic [NUM_M-1:0] err_r;

   // Address decode, per-slave candidates and the "previous owner still asks" lock input.
   always_comb begin
      for (int m = 0; m < NUM_M; m++) begin
         dec_s[m] = region_decode(8'(i_m_addr[m*AW+DEC_LSB +: RW]), NUM_S);
      end
      for (int s = 0; s < NUM_S; s++) begin
         for (int m = 0; m < NUM_M; m++) begin
            cand_s[s][m] = i_m_req[m] && dec_s[m].hit && (dec_s[m].idx == slv_idx_t'(s));
         end
         keep_s[s] = |(cand_s[s] & sgnt_r[s]);
      end
   end

   for (genvar gs = 0; gs < NUM_S; gs++) begin : g_arb
      sys_xbar_rr_arb #(
         .NUM_M    (NUM_M),
         .MAX_HOLD (MAX_HOLD)
      ) u_arb (
         .clk  (i_clk),
         .rst  (i_rst),
         .cand (cand_s[gs]),
         .keep (keep_s[gs]),
         .gnt  (sgnt_s[gs])
      );
   end

   // Master grants and one-hot AND-OR slave muxes; an unowned slave sees all zeros.
   always_comb begin
      o_m_addr_blank: begin end
      unmap_s   = {NUM_M{1'b0}};
      rd_s      = {NUM_M{1'b0}};
      o_s_addr  = {(NUM_S*AW){1'b0}};
      o_s_write = {NUM_S{1'b0}};
      o_s_read  = {NUM_S{1'b0}};
      o_s_size  = {(NUM_S*4){1'b0}};
      o_s_din   = {(NUM_S*DW){1'b0}};
      for (int m = 0; m < NUM_M; m++) begin
         unmap_s[m] = i_m_req[m] && !dec_s[m].hit && !i_rst;
      end
      o_m_gnt = unmap_s;
      for (int s = 0; s < NUM_S; s++) begin
         for (int m = 0; m < NUM_M; m++) begin
            o_m_gnt[m]            = o_m_gnt[m] | sgnt_s[s][m];
            rd_s[m]               = rd_s[m] | (sgnt_s[s][m] & i_m_read[m]);
            o_s_addr[s*AW +: AW]  = o_s_addr[s*AW +: AW] | (i_m_addr[m*AW +: AW] & {AW{sgnt_s[s][m]}});
            o_s_write[s]          = o_s_write[s] | (i_m_write[m] & sgnt_s[s][m]);
            o_s_read[s]           = o_s_read[s] | (i_m_read[m] & sgnt_s[s][m]);
            o_s_size[s*4 +: 4]    = o_s_size[s*4 +: 4] | (i_m_size[m*4 +: 4] & {4{sgnt_s[s][m]}});
            o_s_din[s*DW +: DW]   = o_s_din[s*DW +: DW] | (i_m_din[m*DW +: DW] & {DW{sgnt_s[s][m]}});
         end
      end
   end

   // Response routing state: slave select per master, read-valid, error and last slave grants.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rsp_vld_r <= {NUM_M{1'b0}};
         err_r     <= {NUM_M{1'b0}};
         for (int m = 0; m < NUM_M; m++) begin
            rsp_sel_r[m] <= 4'd0;
         end
         for (int s = 0; s < NUM_S; s++) begin
            sgnt_r[s] <= {NUM_M{1'b0}};
         end
      end else begin
         rsp_vld_r <= rd_s;
         err_r     <= unmap_s;
         for (int m = 0; m < NUM_M; m++) begin
            rsp_sel_r[m] <= rd_s[m] ? dec_s[m].idx : rsp_sel_r[m];
         end
         for (int s = 0; s < NUM_S; s++) begin
            sgnt_r[s] <= sgnt_s[s];
         end
      end
   end

   // Read data follows the registered select; writes and idle cycles return zero.
   always_comb begin
      o_m_dout = {(NUM_M*DW){1'b0}};
      o_m_err  = err_r;
      for (int m = 0; m < NUM_M; m++) begin
         for (int s = 0; s < NUM_S; s++) begin
            o_m_dout[m*DW +: DW] = o_m_dout[m*DW +: DW] |
               (i_s_dout[s*DW +: DW] & {DW{rsp_vld_r[m] && (rsp_sel_r[m] == slv_idx_t'(s))}});
         end
      end
   end

endmodule

// File: tb/tb_sys_xbar.sv
// tb_sys_xbar: directed scenarios followed by constrained-random traffic, each cycle
// compared against a behavioural model of decode, arbitration and response routing.
module tb_sys_xbar;

   localparam int NM = 4;
   localparam int NS = 5;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NM-1:0]    m_req, m_gnt, m_write, m_read, m_err;
   logic [NM*AW-1:0] m_addr;
   logic [NM*4-1:0]  m_size;
   logic [NM*DW-1:0] m_din, m_dout;
   logic [NS*AW-1:0] s_addr;
   logic [NS-1:0]    s_write, s_read;
   logic [NS*4-1:0]  s_size;
   logic [NS*DW-1:0] s_din, s_dout;

   always #5 clk = ~clk;

   sys_xbar #(
      .NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW),
      .DEC_MSB(31), .DEC_LSB(28), .MAX_HOLD(MH)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m_req(m_req), .o_m_gnt(m_gnt), .i_m_addr(m_addr),
      .i_m_write(m_write), .i_m_read(m_read), .i_m_size(m_size),
      .i_m_din(m_din), .o_m_dout(m_dout), .o_m_err(m_err),
      .o_s_addr(s_addr), .o_s_write(s_write), .o_s_read(s_read),
      .o_s_size(s_size), .o_s_din(s_din), .i_s_dout(s_dout)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic        req_a [NM];
   logic        wr_a  [NM];
   logic        rd_a  [NM];
   logic [31:0] addr_a [NM];
   logic [31:0] din_a  [NM];
   logic [3:0]  size_a [NM];
   logic [31:0] sdout_a [NS];
   logic [3:0]  reg_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h3, 4'h0};

   // model state: owner and run length per slave, next search start, pending responses
   int   own [NS];
   int   run [NS];
   int   ptr [NS];
   int   win [NS];
   logic rv  [NM];
   int   rsel [NM];
   logic er  [NM];

   logic [NM-1:0]    e_gnt, e_err;
   logic [NM*DW-1:0] e_dout;
   logic [NS*AW-1:0] e_saddr;
   logic [NS-1:0]    e_swr, e_srd;
   logic [NS*4-1:0]  e_ssize;
   logic [NS*DW-1:0] e_sdin;

   function automatic int decode(input logic [31:0] a);
      case (a[31:28])
         4'h1:    return 0;
         4'h2:    return 1;
         4'h4:    return 2;
         4'h8:    return 3;
         4'hF:    return 4;
         default: return -1;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         own[s] = -1; run[s] = 0; ptr[s] = 0; win[s] = -1;
      end
      for (int m = 0; m < NM; m++) begin
         rv[m] = 1'b0; rsel[m] = 0; er[m] = 1'b0;
      end
   endtask

   task automatic idle_all();
      for (int m = 0; m < NM; m++) begin
         req_a[m] = 1'b0; wr_a[m] = 1'b0; rd_a[m] = 1'b0;
         addr_a[m] = 32'h0; din_a[m] = 32'h0; size_a[m] = 4'h0;
      end
   endtask

   task automatic apply();
      for (int m = 0; m < NM; m++) begin
         m_req[m] = req_a[m]; m_write[m] = wr_a[m]; m_read[m] = rd_a[m];
         m_addr[m*AW +: AW] = addr_a[m]; m_din[m*DW +: DW] = din_a[m];
         m_size[m*4 +: 4] = size_a[m];
      end
      for (int s = 0; s < NS; s++) s_dout[s*DW +: DW] = sdout_a[s];
   endtask

   task automatic model_comb();
      int d, n_oth;
      e_gnt = '0; e_err = '0; e_dout = '0; e_saddr = '0;
      e_swr = '0; e_srd = '0; e_ssize = '0; e_sdin = '0;
      for (int s = 0; s < NS; s++) begin
         win[s] = -1;
         n_oth  = 0;
         for (int m = 0; m < NM; m++)
            if (req_a[m] && decode(addr_a[m]) == s && m != own[s]) n_oth++;
         if (own[s] >= 0)
            if (req_a[own[s]] && decode(addr_a[own[s]]) == s && (run[s] < MH || n_oth == 0))
               win[s] = own[s];
         if (win[s] < 0)
            for (int k = 0; k < NM; k++) begin
               d = (ptr[s] + k) % NM;
               if (win[s] < 0 && req_a[d] && decode(addr_a[d]) == s) win[s] = d;
            end
      end
      if (!rst) begin
         for (int m = 0; m < NM; m++) begin
            d = decode(addr_a[m]);
            if (req_a[m] && (d < 0 || win[d] == m)) e_gnt[m] = 1'b1;
         end
         for (int s = 0; s < NS; s++)
            if (win[s] >= 0) begin
               e_saddr[s*AW +: AW] = addr_a[win[s]];
               e_swr[s] = wr_a[win[s]];
               e_srd[s] = rd_a[win[s]];
               e_ssize[s*4 +: 4] = size_a[win[s]];
               e_sdin[s*DW +: DW] = din_a[win[s]];
            end
      end
      for (int m = 0; m < NM; m++) begin
         e_err[m] = er[m];
         if (rv[m]) e_dout[m*DW +: DW] = sdout_a[rsel[m]];
      end
   endtask

   task automatic model_seq();
      int d;
      for (int s = 0; s < NS; s++) begin
         if (win[s] >= 0) begin
            run[s] = (win[s] == own[s]) ? run[s] + 1 : 1;
            own[s] = win[s];
            ptr[s] = (win[s] + 1) % NM;
         end else begin
            own[s] = -1; run[s] = 0;
         end
      end
      for (int m = 0; m < NM; m++) begin
         d = decode(addr_a[m]);
         rv[m] = e_gnt[m] && d >= 0 && rd_a[m];
         if (rv[m]) rsel[m] = d;
         er[m] = req_a[m] && d < 0;
      end
   endtask

   task automatic settle();
      apply();
      model_comb();
      @(negedge clk);
      chk("m_gnt", m_gnt, e_gnt);
      chk("s_addr", s_addr, e_saddr);
      chk("s_write", s_write, e_swr);
      chk("s_read", s_read, e_srd);
      chk("s_size", s_size, e_ssize);
      chk("s_din", s_din, e_sdin);
      chk("m_dout", m_dout, e_dout);
      chk("m_err", m_err, e_err);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_seq();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      idle_all();
      settle();
      tick();
      rst = 1'b0;
   endtask

   task automatic rand_master(input int m);
      req_a[m]  = ($urandom_range(1) == 1);
      addr_a[m] = {reg_tab[$urandom_range(6)], 28'($urandom)};
      rd_a[m]   = ($urandom_range(1) == 1);
      wr_a[m]   = !rd_a[m];
      size_a[m] = 4'($urandom);
      din_a[m]  = $urandom;
   endtask

   initial begin
      logic [3:0] pat;
      rst = 1'b1;
      for (int s = 0; s < NS; s++) sdout_a[s] = 32'h0;
      idle_all();
      model_reset();
      e_gnt = '0;

      // single read through slave 0
      do_reset();
      sdout_a[0] = 32'hCAFE_0001;
      req_a[0] = 1'b1; rd_a[0] = 1'b1; addr_a[0] = 32'h1000_0010; size_a[0] = 4'hF;
      settle();
      chk("t1_gnt0", m_gnt[0], 1'b1);
      chk("t1_sread0", s_read[0], 1'b1);
      tick();
      idle_all();
      settle();
      chk("t1_dout0", m_dout[31:0], 32'hCAFE_0001);
      tick();

      // two masters contend for region 1: alternating runs of MH cycles
      do_reset();
      req_a[0] = 1'b1; rd_a[0] = 1'b1; addr_a[0] = 32'h1000_0000;
      req_a[1] = 1'b1; rd_a[1] = 1'b1; addr_a[1] = 32'h1000_0004;
      for (int i = 0; i < 16; i++) begin
         settle();
         pat = (((i / MH) % 2) == 0) ? 4'b0001 : 4'b0010;
         chk("t2_alt", m_gnt, pat);
         tick();
      end
      idle_all();

      // parallel accesses to two different slaves
      req_a[0] = 1'b1; wr_a[0] = 1'b1; addr_a[0] = 32'h2000_0040; din_a[0] = 32'h1234_5678; size_a[0] = 4'hF;
      req_a[2] = 1'b1; rd_a[2] = 1'b1; addr_a[2] = 32'h8000_0004; size_a[2] = 4'h3;
      settle();
      chk("t3_gnt", m_gnt, 4'b0101);
      chk("t3_addr1", s_addr[1*AW +: AW], 32'h2000_0040);
      chk("t3_din1", s_din[1*DW +: DW], 32'h1234_5678);
      chk("t3_wr1", s_write[1], 1'b1);
      chk("t3_addr3", s_addr[3*AW +: AW], 32'h8000_0004);
      chk("t3_rd3", s_read[3], 1'b1);
      chk("t3_idle_addr", {s_addr[4*AW +: AW], s_addr[2*AW +: AW], s_addr[0 +: AW]}, 96'h0);
      tick();
      idle_all();

      // unmapped access from M3
      req_a[3] = 1'b1; rd_a[3] = 1'b1; addr_a[3] = 32'h3000_0000;
      settle();
      chk("t4_gnt3", m_gnt[3], 1'b1);
      chk("t4_noread", s_read, 5'b00000);
      tick();
      idle_all();
      settle();
      chk("t4_err3", m_err[3], 1'b1);
      chk("t4_dout3", m_dout[3*DW +: DW], 32'h0);
      tick();
      settle();
      chk("t4_err3_clr", m_err[3], 1'b0);
      tick();

      // back-to-back reads from M1 to slaves 0 and 3
      sdout_a[0] = 32'hAAAA_0000; sdout_a[3] = 32'hBBBB_0003;
      req_a[1] = 1'b1; rd_a[1] = 1'b1; addr_a[1] = 32'h1000_0100;
      settle();
      tick();
      addr_a[1] = 32'h8000_0200;
      settle();
      chk("t5_dout_s0", m_dout[1*DW +: DW], 32'hAAAA_0000);
      tick();
      idle_all();
      settle();
      chk("t5_dout_s3", m_dout[1*DW +: DW], 32'hBBBB_0003);
      tick();

      // reset in the middle of a held lock
      do_reset();
      req_a[0] = 1'b1; rd_a[0] = 1'b1; addr_a[0] = 32'h1000_0000;
      req_a[1] = 1'b1; rd_a[1] = 1'b1; addr_a[1] = 32'h1000_0008;
      for (int i = 0; i < 3; i++) begin
         settle();
         tick();
      end
      rst = 1'b1;
      model_reset();
      settle();
      chk("t6_gnt_rst", m_gnt, 4'b0000);
      chk("t6_sread_rst", s_read, 5'b00000);
      chk("t6_dout_rst", m_dout, 128'h0);
      tick();
      rst = 1'b0;
      req_a[0] = 1'b0;
      req_a[2] = 1'b1; rd_a[2] = 1'b1; addr_a[2] = 32'h1000_000C;
      settle();
      chk("t6_fresh", m_gnt, 4'b0010);
      tick();

      // constrained-random traffic; losers hold, owners usually continue their burst
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(149) == 0) begin
            do_reset();
         end
         for (int m = 0; m < NM; m++)
            if (!(req_a[m] && (!e_gnt[m] || $urandom_range(3) != 0))) rand_master(m);
         for (int s = 0; s < NS; s++) sdout_a[s] = $urandom;
         settle();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
